// File: rtl/pe_pkg.sv
// pe_pkg: definitions shared by the PE feeder and the Pe processing element.
// Holds the default sample/coefficient width and block length. It also holds
// the encoded FSM state type and its state constants used by pe_feeder.
package pe_pkg;

  localparam int PE_DATA_WIDTH = 8;
  localparam int PE_BLOCK_LEN  = 8;

  typedef logic [1:0] feeder_state_t;

  localparam feeder_state_t ST_FILL   = 2'd0;
  localparam feeder_state_t ST_STREAM = 2'd1;
  localparam feeder_state_t ST_DRAIN  = 2'd2;

endpackage

// File: rtl/pe_feeder_buf.sv
// pe_feeder_buf: block buffer holding one block of samples for the PE feeder.
// BLOCK_LEN x DATA_WIDTH storage with one synchronous write port and one
// asynchronous read port. The contents are not reset.
// Ports:
//   clk        - clock, rising edge
//   i_we       - write enable
//   i_wr_addr  - write index
//   i_wr_data  - write data
//   i_rd_addr  - read index
//   o_rd_data  - read data, combinational from i_rd_addr
module pe_feeder_buf
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int BLOCK_LEN  = PE_BLOCK_LEN
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(BLOCK_LEN)-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic [$clog2(BLOCK_LEN)-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0]        o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [BLOCK_LEN];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: collects a block of samples and replays it to a PE chain.
// The sample stream is replayed with load/sum-diff control and a per-block
// coefficient. Each block is followed by idle cycles that flush the chain.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   sData/sValid/sReady      - upstream sample handshake
//   cfgCoef/cfgCoefWe        - coefficient write into the shadow register
//   xOut, zOut               - PE sample and partial-sum inputs (zOut is 0)
//   CoefficientOut           - coefficient latched for the current block
//   loadOut, sumDiffSelOut   - PE control
//   outValid, busy           - xOut valid, feeder streaming or draining
//
// state     | meaning
// ST_FILL   | accepting samples into the buffer, sReady=1
// ST_STREAM | replaying buffer[0..BLOCK_LEN-1], one per cycle
// ST_DRAIN  | DRAIN_CYCLES idle cycles with outputs zeroed
module pe_feeder
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = PE_DATA_WIDTH,
  parameter int BLOCK_LEN    = PE_BLOCK_LEN,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sData,
  input  logic                  sValid,
  output logic                  sReady,
  input  logic [DATA_WIDTH-1:0] cfgCoef,
  input  logic                  cfgCoefWe,
  output logic [DATA_WIDTH-1:0] xOut,
  output logic [DATA_WIDTH-1:0] zOut,
  output logic [DATA_WIDTH-1:0] CoefficientOut,
  output logic                  loadOut,
  output logic                  sumDiffSelOut,
  output logic                  outValid,
  output logic                  busy
);

  localparam int IDX_W = $clog2(BLOCK_LEN);
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  feeder_state_t         r_state;
  logic [IDX_W-1:0]      r_wr_idx;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [CNT_W-1:0]      r_drain_cnt;
  logic [DATA_WIDTH-1:0] r_coef_shadow;
  logic [DATA_WIDTH-1:0] r_coef_active;
  logic [DATA_WIDTH-1:0] r_x_out;
  logic                  r_load;
  logic                  r_sel;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_last_wr;
  logic                  w_emit;
  logic                  w_to_drain;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign sReady     = (r_state == ST_FILL);
  assign w_accept   = sValid & sReady;
  assign w_last_wr  = w_accept & (r_wr_idx == LAST_IDX);
  // r_rd_idx is the index of the next sample to present. It wraps to 0 once
  // the last sample of the block has been presented, which ends STREAM.
  assign w_emit     = w_last_wr | ((r_state == ST_STREAM) & (r_rd_idx != '0));
  assign w_to_drain = (r_state == ST_STREAM) & (r_rd_idx == '0);

  pe_feeder_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .BLOCK_LEN (BLOCK_LEN)
  ) u_buf (
    .clk       (clk),
    .i_we      (w_accept),
    .i_wr_addr (r_wr_idx),
    .i_wr_data (sData),
    .i_rd_addr (r_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_wr_idx      <= '0;
      r_rd_idx      <= '0;
      r_drain_cnt   <= '0;
      r_coef_shadow <= '0;
      r_coef_active <= '0;
      r_x_out       <= '0;
      r_load        <= 1'b0;
      r_sel         <= 1'b0;
      r_valid       <= 1'b0;
    end else begin
      if (cfgCoefWe) r_coef_shadow <= cfgCoef;

      case (r_state)
        ST_FILL: begin
          if (w_accept) r_wr_idx <= r_wr_idx + 1'b1;
          if (w_last_wr) begin
            r_state       <= ST_STREAM;
            // A write landing on the same edge belongs to this block.
            r_coef_active <= cfgCoefWe ? cfgCoef : r_coef_shadow;
          end
        end
        ST_STREAM: begin
          if (w_to_drain) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) r_state <= ST_FILL;
          else r_drain_cnt <= r_drain_cnt - 1'b1;
        end
        default: r_state <= ST_FILL;
      endcase

      // buffer[0] is already stored when the last sample is accepted, so the
      // first block sample can be registered on that same edge.
      if (w_emit) begin
        r_x_out  <= w_rd_data;
        r_load   <= (r_rd_idx <= IDX_W'(1));
        r_sel    <= r_rd_idx[0];
        r_valid  <= 1'b1;
        r_rd_idx <= r_rd_idx + 1'b1;
      end else if (w_to_drain) begin
        r_x_out <= '0;
        r_load  <= 1'b0;
        r_sel   <= 1'b0;
        r_valid <= 1'b0;
      end
    end
  end

  assign xOut           = r_x_out;
  assign zOut           = '0;
  assign CoefficientOut = r_coef_active;
  assign loadOut        = r_load;
  assign sumDiffSelOut  = r_sel;
  assign outValid       = r_valid;
  assign busy           = (r_state == ST_STREAM) | (r_state == ST_DRAIN);

endmodule

// File: tb/tb_pe_feeder.sv
module tb_pe_feeder;

  localparam int BL = 8;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sData;
  logic       sValid;
  logic       sReady;
  logic [7:0] cfgCoef;
  logic       cfgCoefWe;
  logic [7:0] xOut, zOut, CoefficientOut;
  logic       loadOut, sumDiffSelOut, outValid, busy;

  typedef struct packed {
    logic [7:0] x;
    logic       load;
    logic       sel;
    logic [7:0] coef;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  pe_feeder #(.DATA_WIDTH(8), .BLOCK_LEN(BL), .DRAIN_CYCLES(DC)) dut (
    .clk            (clk),
    .rst            (rst),
    .sData          (sData),
    .sValid         (sValid),
    .sReady         (sReady),
    .cfgCoef        (cfgCoef),
    .cfgCoefWe      (cfgCoefWe),
    .xOut           (xOut),
    .zOut           (zOut),
    .CoefficientOut (CoefficientOut),
    .loadOut        (loadOut),
    .sumDiffSelOut  (sumDiffSelOut),
    .outValid       (outValid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every valid output pops one expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("zout", zOut, 0);
      if (outValid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_empty_on_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("xout", xOut, e.x);
          chk("load", loadOut, e.load);
          chk("sel",  sumDiffSelOut, e.sel);
          chk("coef", CoefficientOut, e.coef);
          chk("busy_stream", busy, 1);
        end
      end
    end
  end

  task automatic write_coef(input logic [7:0] v);
    cfgCoefWe = 1'b1;
    cfgCoef   = v;
    @(posedge clk); #1;
    cfgCoefWe = 1'b0;
  endtask

  // Feeds one block starting at base. Expected entries are pushed once the
  // block is complete, carrying the coefficient the block should latch.
  task automatic feed(input logic [7:0] base, input bit gappy,
                      input bit we_last, input logic [7:0] we_val,
                      input logic [7:0] exp_coef);
    int  k = 0;
    int  it = 0;
    bit  hs;
    logic [7:0] d;
    while (k < BL) begin
      if (gappy && (it % 2 == 1)) begin
        sValid = 1'b0;
      end else begin
        sValid = 1'b1;
        d      = base + 8'(k);
        sData  = d;
      end
      cfgCoefWe = we_last && (k == BL - 1) && sValid;
      cfgCoef   = we_val;
      hs = sValid && sReady;
      @(posedge clk); #1;
      cfgCoefWe = 1'b0;
      if (hs) k++;
      it++;
      if (it > 64) begin
        chk("feed_timeout", 1, 0);
        break;
      end
    end
    sValid = 1'b0;
    for (int j = 0; j < BL; j++) begin
      exp_t e;
      e.x    = base + 8'(j);
      e.load = (j < 2);
      e.sel  = j[0];
      e.coef = exp_coef;
      sb.push_back(e);
    end
  endtask

  // Watches STREAM + DRAIN following the final accept. Optionally writes a
  // coefficient at stream index wr_at, and optionally holds sValid high.
  task automatic watch(input int wr_at, input logic [7:0] wr_val,
                       input bit hold, input logic [7:0] exp_coef);
    for (int c = 0; c < BL + DC; c++) begin
      @(negedge clk);
      chk("rdy_low", sReady, 0);
      chk("vld", outValid, (c < BL));
      if (c >= BL) begin
        chk("drain_x", xOut, 0);
        chk("drain_ctl", {loadOut, sumDiffSelOut}, 0);
        chk("drain_coef", CoefficientOut, exp_coef);
        chk("drain_busy", busy, 1);
      end
      if (hold) begin
        sValid = 1'b1;
        sData  = 8'hEE;
      end
      cfgCoefWe = (c == wr_at);
      cfgCoef   = wr_val;
    end
    @(negedge clk);
    cfgCoefWe = 1'b0;
    chk("rdy_back", sReady, 1);
    chk("idle_vld", outValid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; sValid = 1'b0; sData = '0; cfgCoef = '0; cfgCoefWe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x", xOut, 0);
    chk("rst_ctl", {loadOut, sumDiffSelOut, outValid, busy}, 0);
    chk("rst_coef", CoefficientOut, 0);
    chk("rst_z", zOut, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", sReady, 1);

    // Back-to-back block with coefficient 1.
    write_coef(8'd1);
    feed(8'd0, 1'b0, 1'b0, 8'd0, 8'd1);
    watch(-1, 8'd0, 1'b0, 8'd1);

    // Same block fed with sValid toggling.
    feed(8'd0, 1'b1, 1'b0, 8'd0, 8'd1);
    watch(-1, 8'd0, 1'b0, 8'd1);

    // Mid-stream coefficient write only affects the following block.
    feed(8'd20, 1'b0, 1'b0, 8'd0, 8'd1);
    watch(3, 8'd5, 1'b0, 8'd1);
    feed(8'd30, 1'b1, 1'b0, 8'd0, 8'd5);
    // sValid held high through STREAM+DRAIN must not store anything.
    watch(-1, 8'd0, 1'b1, 8'd5);

    // Write coincident with the last accept is taken by that block.
    feed(8'd50, 1'b0, 1'b1, 8'd9, 8'd9);
    watch(-1, 8'd0, 1'b0, 8'd9);

    // Reset at stream index 4 abandons the block.
    feed(8'd60, 1'b0, 1'b0, 8'd0, 8'd9);
    for (int c = 0; c < 4; c++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("mrst_x", xOut, 0);
    chk("mrst_ctl", {loadOut, sumDiffSelOut, outValid, busy}, 0);
    chk("mrst_coef", CoefficientOut, 0);
    chk("mrst_rdy", sReady, 1);
    rst = 1'b0;
    feed(8'd10, 1'b0, 1'b0, 8'd0, 8'd0);
    watch(-1, 8'd0, 1'b0, 8'd0);

    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
